alu_exec: RTL and testbench
===========================

Name: alu_exec

Overview:
Parametrised execute-stage ALU. Decodes RV funct3/funct7 internally into the ten base ops (add, sub, and, or, xor, sll, srl, sra, slt, sltu), executes them, and returns a registered result over a valid/ready handshake.
Shifts run iteratively, SHIFT_STEP bits per cycle, to bound barrel-shifter area.
Sits between the issue stage and writeback; one operation in flight at a time.

Parameters:
XLEN, 32, datapath width; power of two, at least 8.
SHIFT_STEP, 4, maximum shift distance per cycle; 1..XLEN, power of two. SHIFT_STEP=XLEN gives single-cycle shifts.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
flush  in  1  synchronous cancel of any in-flight or held op.
in_valid  in  1  op request.
in_ready  out  1  op accepted on in_valid&&in_ready.
funct3  in  3  RV funct3.
funct7  in  7  RV funct7, or imm[11:5] for I-type.
funct7_en  in  1  1 = R-type, so funct7 is meaningful for add/sub.
src1  in  XLEN  operand A.
src2  in  XLEN  operand B or immediate; shamt = src2[log2(XLEN)-1:0].
out_valid  out  1  result available.
out_ready  in  1  result consumed on out_valid&&out_ready.
result  out  XLEN  registered result.
illegal  out  1  qualifies result: encoding not supported.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; out_valid=0, result=0, illegal=0.
  - in_ready=1 once rst_n deasserts.
  - An op in flight when reset asserts is discarded.
- Decode, funct3:
  - 000: add; sub when funct7_en=1 and funct7=0100000.
  - 001: sll. 010: slt. 011: sltu. 100: xor. 101: srl, or sra when funct7=0100000. 110: or. 111: and.
- Illegal encodings, checked in this order:
  - funct3 001/101: funct7 is always checked, whether or not funct7_en is set.
  - funct3 000: funct7 checked only when funct7_en=1.
  - All other funct3: funct7 checked only when funct7_en=1.
  - Legal funct7 values are 0000000, plus 0100000 for funct3 000/101 only.
  - Anything else is illegal: illegal=1, result=0, latency 1.
- Arithmetic:
  - add/sub wrap modulo 2^XLEN.
  - slt/sltu produce {XLEN-1 zeros, bit}.
  - sra replicates src1[XLEN-1].
- Handshake: in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- FSM states: IDLE, SHIFT, plus MUL when the macro is defined.
- IDLE on accept:
  - Non-shift, illegal, or shamt=0: result and out_valid=1 are registered on the same edge (latency 1).
  - Shift with shamt>0: acc <= src1 shifted by min(SHIFT_STEP, shamt); rem <= shamt - min(SHIFT_STEP, shamt).
    - rem=0: result/out_valid set on that edge.
    - Otherwise go to SHIFT.
- SHIFT: each cycle shift acc by min(SHIFT_STEP, rem) and decrement rem. When rem reaches 0, result <= acc, out_valid=1, go to IDLE.
- Shift latency = ceil(shamt/SHIFT_STEP) cycles, minimum 1. in_ready=0 throughout SHIFT.
- Output hold: result and illegal stay stable while out_valid=1 and out_ready=0.
- Back-to-back: when out_valid&&out_ready and in_valid&&in_ready in the same cycle, the new result replaces the old one with no bubble.
- flush (priority over all else except reset): next edge state=IDLE, out_valid=0; any input offered that cycle is not accepted.
- Upper src2 bits above shamt are ignored for shifts.

Optional Feature:
Macro: ALU_MUL_EN.
- Defined: funct7=0000001 with funct7_en=1 and funct3=000 is decoded as mul.
  - Produces the low XLEN bits of src1*src2.
  - Shift-add, one bit per cycle, MUL state.
  - Latency XLEN cycles; in_ready=0 meanwhile; flush/reset abort it.
- Undefined: that encoding is illegal (illegal=1, result=0, latency 1). No MUL state or multiplier logic is built.
- funct7=0000001 with funct7_en=0, or with any other funct3, is illegal in both builds.

Test Plan:
1. XLEN=32, SHIFT_STEP=4: add src1=5, src2=7, funct3=000, funct7=0, funct7_en=1 -> one cycle later out_valid=1, result=12, illegal=0.
2. src1=3, src2=5, funct3=000, funct7=0100000, funct7_en=1 -> result=0xFFFFFFFE. Same with funct7_en=0 -> result=8 (addi).
3. sra src1=0x80000000, src2=0x29 (shamt=9) -> in_ready=0 for 2 cycles, out_valid on the 3rd edge, result=0xFFC00000. Same with SHIFT_STEP=32 -> 1 cycle.
4. Hold out_ready=0 for 5 cycles after a result of 0x1234 -> result stays 0x1234 and in_ready=0. Then raise out_ready with a new xor 0xF0^0x0F offered -> accepted the same cycle, next result 0xFF.
5. funct7=0000001, funct3=000, funct7_en=1, src1=6, src2=7:
   - Without ALU_MUL_EN -> illegal=1, result=0 after 1 cycle.
   - With ALU_MUL_EN -> result=42, out_valid after 32 cycles.
   - funct3=010 with funct7=0100000 -> illegal=1 in both builds.
6. Start sll shamt=31 with SHIFT_STEP=1:
   - Assert flush at cycle 3 -> out_valid stays 0, in_ready=1 next cycle.
   - Repeat, pulsing rst_n=0 mid-shift -> out_valid=0 and result=0 immediately.

Source files
------------

// File: rtl/alu_exec_if.sv
// Issue/writeback handshake bundle for alu_exec: op request in, registered result out.
interface alu_exec_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            funct7_en;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            illegal;

  modport master (
    output in_valid, funct3, funct7, funct7_en, src1, src2, out_ready,
    input  in_ready, out_valid, result, illegal
  );

  modport slave (
    input  in_valid, funct3, funct7, funct7_en, src1, src2, out_ready,
    output in_ready, out_valid, result, illegal
  );
endinterface

// File: rtl/alu_exec.sv
// Execute-stage ALU: RV funct3/funct7 decode, iterative shifter, registered result.
// Define ALU_MUL_EN to add a shift-add multiplier (funct7=0000001, funct3=000, R-type).
module alu_exec #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  alu_exec_if.slave bus
);
  localparam int unsigned SHAMT_W = $clog2(XLEN);
  localparam int unsigned STEP_W  = $clog2(SHIFT_STEP) + 1;
  localparam logic [6:0]  F7_BASE = 7'b0000000;
  localparam logic [6:0]  F7_ALT  = 7'b0100000;
  localparam logic [6:0]  F7_MUL  = 7'b0000001;

`ifdef ALU_MUL_EN
  localparam logic MUL_EN = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, MUL = 2'd2} state_e;
`else
  localparam logic MUL_EN = 1'b0;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_e;
`endif

  typedef enum logic [1:0] {SH_LL = 2'd0, SH_RL = 2'd1, SH_RA = 2'd2} shk_e;

  // Shift by at most SHIFT_STEP positions; bounds the shifter to STEP_W select bits.
  function automatic logic [XLEN-1:0] do_shift(input shk_e k, input logic [XLEN-1:0] x,
                                               input logic [STEP_W-1:0] n);
    case (k)
      SH_LL:   do_shift = x << n;
      SH_RA:   do_shift = XLEN'($signed(x) >>> n);
      default: do_shift = x >> n;
    endcase
  endfunction

  function automatic logic [STEP_W-1:0] step_of(input logic [SHAMT_W-1:0] r);
    if (32'(r) >= SHIFT_STEP) step_of = STEP_W'(SHIFT_STEP);
    else                      step_of = STEP_W'(r);
  endfunction

  state_e              state, state_d;
  shk_e                kind, kind_d;
  logic [XLEN-1:0]     acc, acc_d;
  logic [SHAMT_W-1:0]  rem, rem_d;
  logic [XLEN-1:0]     result, result_d;
  logic                illegal, illegal_d;
  logic                out_valid, out_valid_d;
`ifdef ALU_MUL_EN
  logic [XLEN-1:0]     mcand, mcand_d;
  logic [XLEN-1:0]     mplier, mplier_d;
`endif

  logic                in_ready;
  logic                accept;
  logic [SHAMT_W-1:0]  shamt;
  logic                dec_illegal;
  logic                dec_shift;
  logic                dec_mul;
  shk_e                dec_kind;
  logic [XLEN-1:0]     dec_result;
  logic [STEP_W-1:0]   first_step;
  logic [XLEN-1:0]     first_acc;
  logic [SHAMT_W-1:0]  first_rem;
  logic [STEP_W-1:0]   iter_step;
  logic [XLEN-1:0]     iter_acc;
  logic [SHAMT_W-1:0]  iter_rem;

  assign in_ready      = (state == IDLE) && (!out_valid || bus.out_ready) && !flush;
  assign accept        = bus.in_valid && in_ready;
  assign shamt         = bus.src2[SHAMT_W-1:0];
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = result;
  assign bus.illegal   = illegal;

  // Decode funct3/funct7 into an op, a single-cycle result and the illegal flag.
  always_comb begin
    dec_illegal = 1'b0;
    dec_shift   = 1'b0;
    dec_mul     = 1'b0;
    dec_kind    = SH_LL;
    dec_result  = '0;
    case (bus.funct3)
      3'b000: begin
        dec_result  = (bus.funct7_en && bus.funct7 == F7_ALT) ? bus.src1 - bus.src2
                                                               : bus.src1 + bus.src2;
        dec_mul     = MUL_EN && bus.funct7_en && (bus.funct7 == F7_MUL);
        dec_illegal = bus.funct7_en &&
                      !(bus.funct7 == F7_BASE || bus.funct7 == F7_ALT || dec_mul);
      end
      3'b001: begin
        dec_kind    = SH_LL;
        dec_shift   = 1'b1;
        dec_illegal = (bus.funct7 != F7_BASE);
      end
      3'b101: begin
        dec_kind    = (bus.funct7 == F7_ALT) ? SH_RA : SH_RL;
        dec_shift   = 1'b1;
        dec_illegal = !(bus.funct7 == F7_BASE || bus.funct7 == F7_ALT);
      end
      3'b010: begin
        dec_result  = XLEN'($signed(bus.src1) < $signed(bus.src2));
        dec_illegal = bus.funct7_en && (bus.funct7 != F7_BASE);
      end
      3'b011: begin
        dec_result  = XLEN'(bus.src1 < bus.src2);
        dec_illegal = bus.funct7_en && (bus.funct7 != F7_BASE);
      end
      3'b100: begin
        dec_result  = bus.src1 ^ bus.src2;
        dec_illegal = bus.funct7_en && (bus.funct7 != F7_BASE);
      end
      3'b110: begin
        dec_result  = bus.src1 | bus.src2;
        dec_illegal = bus.funct7_en && (bus.funct7 != F7_BASE);
      end
      default: begin
        dec_result  = bus.src1 & bus.src2;
        dec_illegal = bus.funct7_en && (bus.funct7 != F7_BASE);
      end
    endcase
    // The mul encoding is reserved everywhere except the enabled R-type slot.
    if (bus.funct7 == F7_MUL && !dec_mul) dec_illegal = 1'b1;
    if (dec_shift && shamt == '0) begin
      dec_shift  = 1'b0;
      dec_result = bus.src1;
    end
    if (dec_illegal) begin
      dec_result = '0;
      dec_shift  = 1'b0;
      dec_mul    = 1'b0;
    end
  end

  assign first_step = step_of(shamt);
  assign first_acc  = do_shift(dec_kind, bus.src1, first_step);
  assign first_rem  = shamt - SHAMT_W'(first_step);
  assign iter_step  = step_of(rem);
  assign iter_acc   = do_shift(kind, acc, iter_step);
  assign iter_rem   = rem - SHAMT_W'(iter_step);

  // Next-state and datapath register updates.
  always_comb begin
    state_d     = state;
    kind_d      = kind;
    acc_d       = acc;
    rem_d       = rem;
    result_d    = result;
    illegal_d   = illegal;
    out_valid_d = out_valid;
`ifdef ALU_MUL_EN
    mcand_d     = mcand;
    mplier_d    = mplier;
`endif
    case (state)
      IDLE: begin
        if (bus.out_ready) out_valid_d = 1'b0;
        if (accept) begin
          if (dec_shift) begin
            kind_d = dec_kind;
            acc_d  = first_acc;
            rem_d  = first_rem;
            if (first_rem == '0) begin
              result_d    = first_acc;
              illegal_d   = 1'b0;
              out_valid_d = 1'b1;
            end else begin
              state_d = SHIFT;
            end
`ifdef ALU_MUL_EN
          end else if (dec_mul) begin
            acc_d    = bus.src2[0] ? bus.src1 : '0;
            mcand_d  = {bus.src1[XLEN-2:0], 1'b0};
            mplier_d = {1'b0, bus.src2[XLEN-1:1]};
            rem_d    = SHAMT_W'(XLEN - 1);
            state_d  = MUL;
`endif
          end else begin
            result_d    = dec_result;
            illegal_d   = dec_illegal;
            out_valid_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        acc_d = iter_acc;
        rem_d = iter_rem;
        if (iter_rem == '0) begin
          result_d    = iter_acc;
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
`ifdef ALU_MUL_EN
      MUL: begin
        acc_d    = acc + (mplier[0] ? mcand : '0);
        mcand_d  = {mcand[XLEN-2:0], 1'b0};
        mplier_d = {1'b0, mplier[XLEN-1:1]};
        rem_d    = rem - SHAMT_W'(1);
        if (rem == SHAMT_W'(1)) begin
          result_d    = acc_d;
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      kind      <= SH_LL;
      acc       <= '0;
      rem       <= '0;
      result    <= '0;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
`ifdef ALU_MUL_EN
      mcand     <= '0;
      mplier    <= '0;
`endif
    end else begin
      state     <= state_d;
      kind      <= kind_d;
      acc       <= acc_d;
      rem       <= rem_d;
      result    <= result_d;
      illegal   <= illegal_d;
      out_valid <= out_valid_d;
`ifdef ALU_MUL_EN
      mcand     <= mcand_d;
      mplier    <= mplier_d;
`endif
    end
  end
endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: vector table with a result scoreboard on the SHIFT_STEP=4 instance,
// plus hand sequences on SHIFT_STEP=32 and SHIFT_STEP=1 instances.
module tb_alu_exec;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic        v4 = 1'b0, v1 = 1'b0, v32 = 1'b0;
  logic [2:0]  f3 = '0;
  logic [6:0]  f7 = '0;
  logic        f7en = 1'b0;
  logic [31:0] a = '0, b = '0;
  int          total = 0;
  int          bad = 0;

  typedef struct { logic [31:0] r; logic ill; int id; } exp_t;
  typedef struct {
    logic [2:0] f3; logic [6:0] f7; logic en;
    logic [31:0] a; logic [31:0] b; logic [31:0] r; logic ill; int lat;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[20];

  always #5 clk = ~clk;

  alu_exec_if #(.XLEN(32)) bus4 ();
  alu_exec_if #(.XLEN(32)) bus1 ();
  alu_exec_if #(.XLEN(32)) bus32 ();

  assign bus4.in_valid = v4;    assign bus4.funct3 = f3;   assign bus4.funct7 = f7;
  assign bus4.funct7_en = f7en; assign bus4.src1 = a;      assign bus4.src2 = b;
  assign bus4.out_ready = out_ready;
  assign bus1.in_valid = v1;    assign bus1.funct3 = f3;   assign bus1.funct7 = f7;
  assign bus1.funct7_en = f7en; assign bus1.src1 = a;      assign bus1.src2 = b;
  assign bus1.out_ready = out_ready;
  assign bus32.in_valid = v32;  assign bus32.funct3 = f3;  assign bus32.funct7 = f7;
  assign bus32.funct7_en = f7en; assign bus32.src1 = a;    assign bus32.src2 = b;
  assign bus32.out_ready = out_ready;

  alu_exec #(.XLEN(32), .SHIFT_STEP(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus4));
  alu_exec #(.XLEN(32), .SHIFT_STEP(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus1));
  alu_exec #(.XLEN(32), .SHIFT_STEP(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus32));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Advance to the falling edge and retire any result handed off by the main instance.
  task automatic mon();
    exp_t e;
    @(negedge clk);
    if (rst_n && bus4.out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: result %h appeared with nothing expected", bus4.result);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_result", e.id), bus4.result, e.r);
        chk($sformatf("v%0d_illegal", e.id), 32'(bus4.illegal), 32'(e.ill));
      end
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] f3_, input logic [6:0] f7_, input logic en_,
                        input logic [31:0] a_, input logic [31:0] b_);
    f3 = f3_; f7 = f7_; f7en = en_; a = a_; b = b_;
  endtask

  function automatic vec_t mk(input logic [2:0] f3_, input logic [6:0] f7_, input logic en_,
                              input logic [31:0] a_, input logic [31:0] b_,
                              input logic [31:0] r_, input logic ill_, input int lat_);
    vec_t v;
    v.f3 = f3_; v.f7 = f7_; v.en = en_; v.a = a_; v.b = b_; v.r = r_; v.ill = ill_; v.lat = lat_;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    int n;
    int lat;
    set_op(v.f3, v.f7, v.en, v.a, v.b);
    v4 = 1'b1;
    n = 0;
    mon();
    while (!bus4.in_ready && n < 100) begin
      edge1(); mon(); n++;
    end
    chk($sformatf("v%0d_accept", id), 32'(bus4.in_ready), 32'd1);
    edge1();
    v4 = 1'b0;
    sb.push_back('{r: v.r, ill: v.ill, id: id});
    lat = 1;
    mon();
    while (!bus4.out_valid && lat < 100) begin
      edge1(); mon(); lat++;
    end
    chk($sformatf("v%0d_latency", id), 32'(lat), 32'(v.lat));
    edge1();
  endtask

  initial begin
    int seen;
    vecs[0]  = mk(3'b000, 7'h00, 1'b1, 32'd5, 32'd7, 32'd12, 1'b0, 1);
    vecs[1]  = mk(3'b000, 7'h20, 1'b1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1);
    vecs[2]  = mk(3'b000, 7'h20, 1'b0, 32'd3, 32'd5, 32'd8, 1'b0, 1);
    vecs[3]  = mk(3'b101, 7'h20, 1'b0, 32'h8000_0000, 32'h29, 32'hFFC0_0000, 1'b0, 3);
    vecs[4]  = mk(3'b001, 7'h00, 1'b1, 32'd1, 32'h1F, 32'h8000_0000, 1'b0, 8);
    vecs[5]  = mk(3'b101, 7'h00, 1'b0, 32'hF000_0000, 32'hFFFF_FF04, 32'h0F00_0000, 1'b0, 1);
    vecs[6]  = mk(3'b001, 7'h00, 1'b0, 32'hDEAD_BEEF, 32'h20, 32'hDEAD_BEEF, 1'b0, 1);
    vecs[7]  = mk(3'b010, 7'h00, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1);
    vecs[8]  = mk(3'b011, 7'h00, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
    vecs[9]  = mk(3'b100, 7'h00, 1'b1, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1);
    vecs[10] = mk(3'b111, 7'h00, 1'b1, 32'hF0F0, 32'h0FF0, 32'h00F0, 1'b0, 1);
    vecs[11] = mk(3'b110, 7'h7F, 1'b0, 32'h0F0F, 32'hF000, 32'hFF0F, 1'b0, 1);
    vecs[12] = mk(3'b010, 7'h20, 1'b1, 32'd5, 32'd3, 32'd0, 1'b1, 1);
    vecs[13] = mk(3'b001, 7'h20, 1'b0, 32'd1, 32'd1, 32'd0, 1'b1, 1);
`ifdef ALU_MUL_EN
    vecs[14] = mk(3'b000, 7'h01, 1'b1, 32'd6, 32'd7, 32'd42, 1'b0, 32);
`else
    vecs[14] = mk(3'b000, 7'h01, 1'b1, 32'd6, 32'd7, 32'd0, 1'b1, 1);
`endif
    vecs[15] = mk(3'b000, 7'h01, 1'b0, 32'd6, 32'd7, 32'd0, 1'b1, 1);
    vecs[16] = mk(3'b101, 7'h01, 1'b0, 32'd8, 32'd1, 32'd0, 1'b1, 1);
    vecs[17] = mk(3'b000, 7'h00, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, 1);
    vecs[18] = mk(3'b101, 7'h20, 1'b1, 32'h4000_0000, 32'd5, 32'h0200_0000, 1'b0, 2);
    vecs[19] = mk(3'b101, 7'h00, 1'b1, 32'h8000_0000, 32'd9, 32'h0040_0000, 1'b0, 3);

    // Reset state
    edge1();
    chk("rst_out_valid", 32'(bus4.out_valid), 32'd0);
    chk("rst_result", bus4.result, 32'd0);
    chk("rst_illegal", 32'(bus4.illegal), 32'd0);
    edge1();
    rst_n = 1'b1;
    mon();
    chk("rst_in_ready4", 32'(bus4.in_ready), 32'd1);
    chk("rst_in_ready1", 32'(bus1.in_ready), 32'd1);
    chk("rst_in_ready32", 32'(bus32.in_ready), 32'd1);
    edge1();

    for (int i = 0; i < 20; i++) run_vec(vecs[i], i);

    // Output hold under back-pressure, then same-cycle replacement
    out_ready = 1'b0;
    set_op(3'b000, 7'h00, 1'b1, 32'h1234, 32'd0);
    v4 = 1'b1;
    mon();
    chk("hold_accept", 32'(bus4.in_ready), 32'd1);
    edge1();
    sb.push_back('{r: 32'h1234, ill: 1'b0, id: 100});
    set_op(3'b100, 7'h00, 1'b1, 32'hF0, 32'h0F);
    for (int k = 0; k < 5; k++) begin
      mon();
      chk("hold_result", bus4.result, 32'h1234);
      chk("hold_in_ready", 32'(bus4.in_ready), 32'd0);
      edge1();
    end
    out_ready = 1'b1;
    mon();
    chk("b2b_in_ready", 32'(bus4.in_ready), 32'd1);
    edge1();
    v4 = 1'b0;
    sb.push_back('{r: 32'hFF, ill: 1'b0, id: 101});
    mon();
    chk("b2b_no_bubble", 32'(bus4.out_valid), 32'd1);
    edge1();

    // Flush drops a held result
    out_ready = 1'b0;
    set_op(3'b000, 7'h00, 1'b1, 32'h55, 32'd0);
    v4 = 1'b1;
    mon();
    chk("fheld_accept", 32'(bus4.in_ready), 32'd1);
    edge1();
    v4 = 1'b0;
    mon();
    chk("fheld_valid", 32'(bus4.out_valid), 32'd1);
    flush = 1'b1;
    #1;
    chk("fheld_in_ready", 32'(bus4.in_ready), 32'd0);
    edge1();
    flush = 1'b0;
    void'(sb.pop_back());
    mon();
    chk("fheld_dropped", 32'(bus4.out_valid), 32'd0);
    out_ready = 1'b1;
    edge1();

    // Single-cycle shifter
    set_op(3'b101, 7'h20, 1'b0, 32'h8000_0000, 32'h29);
    v32 = 1'b1;
    mon();
    chk("s32_accept", 32'(bus32.in_ready), 32'd1);
    edge1();
    v32 = 1'b0;
    mon();
    chk("s32_valid", 32'(bus32.out_valid), 32'd1);
    chk("s32_result", bus32.result, 32'hFFC0_0000);
    chk("s32_illegal", 32'(bus32.illegal), 32'd0);
    edge1();

    // Flush mid-shift, then an offer during flush
    set_op(3'b001, 7'h00, 1'b1, 32'd1, 32'h1F);
    v1 = 1'b1;
    mon();
    chk("s1_accept", 32'(bus1.in_ready), 32'd1);
    edge1();
    v1 = 1'b0;
    edge1();
    edge1();
    flush = 1'b1;
    mon();
    chk("s1_flush_busy", 32'(bus1.in_ready), 32'd0);
    edge1();
    flush = 1'b0;
    mon();
    chk("s1_flush_valid", 32'(bus1.out_valid), 32'd0);
    chk("s1_flush_ready", 32'(bus1.in_ready), 32'd1);
    set_op(3'b000, 7'h00, 1'b1, 32'd5, 32'd7);
    v1 = 1'b1;
    flush = 1'b1;
    mon();
    chk("s1_offer_blocked", 32'(bus1.in_ready), 32'd0);
    edge1();
    v1 = 1'b0;
    flush = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      mon();
      if (bus1.out_valid) seen = 1;
      edge1();
    end
    chk("s1_flush_discard", 32'(seen), 32'd0);

    // Reset mid-shift
    set_op(3'b000, 7'h00, 1'b1, 32'd5, 32'd7);
    v1 = 1'b1;
    mon();
    edge1();
    v1 = 1'b0;
    mon();
    chk("s1_pre_result", bus1.result, 32'd12);
    chk("s1_pre_illegal", 32'(bus1.illegal), 32'd0);
    edge1();
    set_op(3'b001, 7'h00, 1'b1, 32'd1, 32'h1F);
    v1 = 1'b1;
    mon();
    chk("s1_rst_accept", 32'(bus1.in_ready), 32'd1);
    edge1();
    v1 = 1'b0;
    repeat (4) edge1();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus1.out_valid), 32'd0);
    chk("mid_rst_result1", bus1.result, 32'd0);
    chk("mid_rst_result4", bus4.result, 32'd0);
    edge1();
    rst_n = 1'b1;
    mon();
    chk("post_rst_ready", 32'(bus1.in_ready), 32'd1);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      mon();
      if (bus1.out_valid) seen = 1;
      edge1();
    end
    chk("post_rst_quiet", 32'(seen), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
